lcd_cmd_seq: RTL and testbench

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

---
 rtl/lcd_cmd_seq.sv | 134 +++++++++++++
 tb/tb_lcd_cmd_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: buffers host opcodes in a small FIFO and issues
// them one at a time to the LCD controller, pacing each issue on the
// controller's busy/done handshake and flagging timeouts or bad opcodes.
module lcd_cmd_seq #(
  parameter int DEPTH = 8,
  parameter int TMO   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_cmd,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  input  logic       done,
  output logic [4:0] fifo_cnt,
  output logic       idle,
  output logic       fault
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);
  localparam logic [7:0] TMO_C   = 8'(TMO);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    WAIT_DONE,
    HALT
  } state_t;

  state_t        state, state_next;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [4:0]    count;
  logic [7:0]    tmo_cnt;
  logic [3:0]    cmd_q;
  logic          fault_q;
  logic          accept, bad_push, push, pop;
  logic          timeout_hit, fault_set, waiting;

  // Host handshake, FIFO push/pop qualification and timeout detection.
  always_comb begin
    in_ready    = (count != DEPTH_C) && (state != HALT) && (state != WAIT_DONE)
                  && !((state == ISSUE) && (cmd_q == 4'd0));
    accept      = in_valid && in_ready;
    bad_push    = accept && (in_cmd >= 4'd12);
    push        = accept && !bad_push;
    pop         = (state == ISSUE);
    waiting     = (state == WAIT_HI) || (state == WAIT_LO) || (state == WAIT_DONE);
    timeout_hit = ({1'b0, tmo_cnt} + 9'd1) >= {1'b0, TMO_C};
  end

  // Next-state logic; an illegal opcode push overrides everything and halts.
  always_comb begin
    state_next = state;
    fault_set  = 1'b0;
    case (state)
      IDLE: begin
        if ((count != 5'd0) && !busy) state_next = ISSUE;
      end
      ISSUE: begin
        if (cmd_q == 4'd0)      state_next = WAIT_DONE;
        else if (cmd_q <= 4'd4) state_next = IDLE;
        else                    state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (busy) state_next = WAIT_LO;
        else if (timeout_hit) begin
          state_next = HALT;
          fault_set  = 1'b1;
        end else if (tmo_cnt == 8'd1) state_next = IDLE;
      end
      WAIT_LO: begin
        if (!busy) state_next = IDLE;
        else if (timeout_hit) begin
          state_next = HALT;
          fault_set  = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (done) state_next = HALT;
        else if (timeout_hit) begin
          state_next = HALT;
          fault_set  = 1'b1;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
    if (bad_push) begin
      state_next = HALT;
      fault_set  = 1'b1;
    end
  end

  // Control state, timeout counter, issued opcode, sticky fault and FIFO bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tmo_cnt <= 8'd0;
      cmd_q   <= 4'd0;
      fault_q <= 1'b0;
      count   <= 5'd0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) tmo_cnt <= 8'd0;
      else if (waiting)        tmo_cnt <= tmo_cnt + 8'd1;
      if ((state == IDLE) && (state_next == ISSUE)) cmd_q <= mem[rd_ptr];
      if (fault_set) fault_q <= 1'b1;
      if (push && !pop)      count <= count + 5'd1;
      else if (pop && !push) count <= count - 5'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // FIFO storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  assign cmd       = cmd_q;
  assign cmd_valid = (state == ISSUE);
  assign fifo_cnt  = count;
  assign idle      = (state == IDLE) && (count == 5'd0);
  assign fault     = fault_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Self-checking bench for lcd_cmd_seq: a queue-based reference model is
// compared against the DUT every cycle, plus literal checks per scenario.
module tb_lcd_cmd_seq;

  localparam int DEPTH = 8;
  localparam int TMO   = 255;

  logic       clk;
  logic       reset;
  logic [3:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic [4:0] fifo_cnt;
  logic       idle;
  logic       fault;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int issCyc[$];
  int issCmd[$];
  int faultCyc = -1;

  // Reference model state: pending opcodes plus what the sequencer is doing.
  int         q[$];
  bit         mHalt, mFault, mIssuing, mWaitLow, mWaitDone;
  int         mHiLeft, mWait;
  logic [3:0] mCmd;

  lcd_cmd_seq #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_cmd   (in_cmd),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .busy     (busy),
    .done     (done),
    .fifo_cnt (fifo_cnt),
    .idle     (idle),
    .fault    (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit mReady();
    return !mHalt && (q.size() < DEPTH) && !mWaitDone && !(mIssuing && (mCmd == 4'd0));
  endfunction

  function automatic bit mIdle();
    return !mHalt && !mIssuing && (mHiLeft == 0) && !mWaitLow && !mWaitDone && (q.size() == 0);
  endfunction

  function automatic int logCmd(input int i);
    return (i < issCmd.size()) ? issCmd[i] : -1;
  endfunction

  function automatic int logCyc(input int i);
    return (i < issCyc.size()) ? issCyc[i] : -1000;
  endfunction

  task automatic modelHalt(input bit withFault);
    mHalt     = 1'b1;
    mFault    = mFault | withFault;
    mIssuing  = 1'b0;
    mHiLeft   = 0;
    mWaitLow  = 1'b0;
    mWaitDone = 1'b0;
  endtask

  task automatic modelReset();
    q.delete();
    mHalt = 0; mFault = 0; mIssuing = 0; mWaitLow = 0; mWaitDone = 0;
    mHiLeft = 0; mWait = 0; mCmd = 4'd0;
  endtask

  task automatic modelStep();
    bit acc, illegal, wasIssuing, startIssue;
    acc        = in_valid && mReady();
    illegal    = acc && (in_cmd >= 4'd12);
    wasIssuing = mIssuing;
    startIssue = 1'b0;
    mIssuing   = 1'b0;
    if (mHalt) begin
    end else if (wasIssuing) begin
      if (mCmd == 4'd0)      begin mWaitDone = 1'b1; mWait = 0; end
      else if (mCmd >= 4'd5) begin mHiLeft = 2; mWait = 0; end
    end else if (mHiLeft > 0) begin
      if (busy) begin mHiLeft = 0; mWaitLow = 1'b1; mWait = 0; end
      else begin
        mWait++;
        if (mWait >= TMO) modelHalt(1'b1);
        else mHiLeft--;
      end
    end else if (mWaitLow) begin
      if (!busy) mWaitLow = 1'b0;
      else begin
        mWait++;
        if (mWait >= TMO) modelHalt(1'b1);
      end
    end else if (mWaitDone) begin
      if (done) modelHalt(1'b0);
      else begin
        mWait++;
        if (mWait >= TMO) modelHalt(1'b1);
      end
    end else if ((q.size() > 0) && !busy) begin
      startIssue = 1'b1;
    end
    if (startIssue && !illegal) begin
      mIssuing = 1'b1;
      mCmd     = 4'(q[0]);
    end
    if (wasIssuing) void'(q.pop_front());
    if (acc && !illegal) q.push_back(int'(in_cmd));
    if (illegal) modelHalt(1'b1);
  endtask

  // Advance the reference model on the same edges the DUT sees.
  always @(posedge clk or negedge reset) begin
    if (!reset) modelReset();
    else        modelStep();
  end

  // Free-running cycle counter used to time issue pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every issue strobe and the first cycle the fault flag appears.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (cmd_valid) begin
        issCyc.push_back(cyc);
        issCmd.push_back(int'(cmd));
      end
      if (fault && (faultCyc < 0)) faultCyc = cyc;
    end
  end

  // Compare all DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checkOutput("model_cmd",       int'(cmd),       int'(mCmd));
      checkOutput("model_cmd_valid", int'(cmd_valid), int'(mIssuing));
      checkOutput("model_in_ready",  int'(in_ready),  int'(mReady()));
      checkOutput("model_fifo_cnt",  int'(fifo_cnt),  q.size());
      checkOutput("model_idle",      int'(idle),      int'(mIdle()));
      checkOutput("model_fault",     int'(fault),     int'(mFault));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] c);
    in_valid = v;
    in_cmd   = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic clearLog();
    issCyc.delete();
    issCmd.delete();
    faultCyc = -1;
  endtask

  task automatic resetDut(input string tag);
    reset = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_rst_cmd"},       int'(cmd),       0);
    checkOutput({tag, "_rst_cmd_valid"}, int'(cmd_valid), 0);
    checkOutput({tag, "_rst_fifo_cnt"},  int'(fifo_cnt),  0);
    checkOutput({tag, "_rst_fault"},     int'(fault),     0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_rel_idle"},     int'(idle),     1);
    checkOutput({tag, "_rel_in_ready"}, int'(in_ready), 1);
    clearLog();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_cmd = 4'd0; busy = 1'b0; done = 1'b0;
    @(posedge clk);
    #1;
    resetDut("init");

    $display("[TB] scenario: shifts 3,4,1 back to back");
    clearLog();
    applyStimulus(1'b1, 4'd3);
    applyStimulus(1'b1, 4'd4);
    applyStimulus(1'b1, 4'd1);
    repeat (8) tick();
    checkOutput("s1_issue_count", issCmd.size(), 3);
    checkOutput("s1_cmd0", logCmd(0), 3);
    checkOutput("s1_cmd1", logCmd(1), 4);
    checkOutput("s1_cmd2", logCmd(2), 1);
    checkOutput("s1_gap01", logCyc(1) - logCyc(0), 2);
    checkOutput("s1_gap12", logCyc(2) - logCyc(1), 2);
    checkOutput("s1_fifo_cnt", int'(fifo_cnt), 0);

    $display("[TB] scenario: opcode 7 with busy handshake");
    clearLog();
    applyStimulus(1'b1, 4'd7);
    tick();
    tick();
    busy = 1'b1;
    applyStimulus(1'b1, 4'd2);
    repeat (3) tick();
    busy = 1'b0;
    repeat (6) tick();
    checkOutput("s2_cmd0", logCmd(0), 7);
    checkOutput("s2_cmd1", logCmd(1), 2);
    checkOutput("s2_gap", logCyc(1) - logCyc(0), 7);
    checkOutput("s2_fault", int'(fault), 0);

    $display("[TB] scenario: opcode 0 then done");
    clearLog();
    applyStimulus(1'b1, 4'd0);
    tick();
    repeat (99) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    applyStimulus(1'b1, 4'd5);
    applyStimulus(1'b1, 4'd3);
    tick();
    checkOutput("s3_in_ready", int'(in_ready), 0);
    checkOutput("s3_fault", int'(fault), 0);
    checkOutput("s3_fifo_cnt", int'(fifo_cnt), 0);
    checkOutput("s3_issue_count", issCmd.size(), 1);
    checkOutput("s3_cmd", int'(cmd), 0);
    resetDut("s3");

    $display("[TB] scenario: opcode 9 with busy stuck high");
    clearLog();
    applyStimulus(1'b1, 4'd9);
    tick();
    busy = 1'b1;
    repeat (300) tick();
    busy = 1'b0;
    tick();
    checkOutput("s4_fault", int'(fault), 1);
    checkOutput("s4_fault_latency", faultCyc - logCyc(0), 257);
    checkOutput("s4_in_ready", int'(in_ready), 0);
    checkOutput("s4_issue_count", issCmd.size(), 1);
    resetDut("s4");

    $display("[TB] scenario: fill FIFO while busy, then drain");
    clearLog();
    busy = 1'b1;
    foreach (issCmd[i]) issCmd[i] = 0;
    begin
      int ops[8] = '{5, 1, 9, 3, 2, 7, 4, 6};
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'(ops[i]));
      checkOutput("s5_full_cnt", int'(fifo_cnt), 8);
      checkOutput("s5_full_ready", int'(in_ready), 0);
      applyStimulus(1'b1, 4'd8);
      checkOutput("s5_ninth_cnt", int'(fifo_cnt), 8);
      busy = 1'b0;
      repeat (50) tick();
      checkOutput("s5_issue_count", issCmd.size(), 8);
      for (int i = 0; i < 8; i++) checkOutput($sformatf("s5_order%0d", i), logCmd(i), ops[i]);
      checkOutput("s5_idle", int'(idle), 1);
    end

    $display("[TB] scenario: illegal opcode 13");
    clearLog();
    busy = 1'b1;
    applyStimulus(1'b1, 4'd2);
    applyStimulus(1'b1, 4'd13);
    repeat (3) tick();
    checkOutput("s6_fault", int'(fault), 1);
    checkOutput("s6_in_ready", int'(in_ready), 0);
    checkOutput("s6_frozen_cnt", int'(fifo_cnt), 1);
    checkOutput("s6_issue_count", issCmd.size(), 0);
    busy = 1'b0;
    resetDut("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
